// File: rtl/cpu_oci_dtrace_packer_if.sv
// Item-in / word-out handshake bundle for the OCI DCT trace packer.
// The packer attaches through the slave modport. The trace source and memory writer use master.
interface cpu_oci_dtrace_packer_if;
  logic        item_valid;
  logic [1:0]  item_data;
  logic        item_ready;
  logic        out_valid;
  logic [35:0] out_data;
  logic        out_ready;

  modport master (
    output item_valid, item_data, out_ready,
    input  item_ready, out_valid, out_data
  );

  modport slave (
    input  item_valid, item_data, out_ready,
    output item_ready, out_valid, out_data
  );
endinterface

// File: rtl/cpu_oci_dtrace_packer.sv
// OCI debug-compressed-trace packer: packs 2-bit items into 30-bit DCT words and sequences flush.
// Optional feature macro: OCI_DTRACE_DROP_CNT_EN (saturating dropped-item counter).
module cpu_oci_dtrace_packer #(
  parameter int MAX_ITEMS = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trc_on,
  input  logic                      flush_req,
  output logic                      flush_done,
  cpu_oci_dtrace_packer_if.slave    bus,
  output logic [29:0]               dct_buffer,
  output logic [3:0]                dct_count,
  output logic [15:0]               drop_cnt
);

  localparam logic [3:0] MAX_C  = 4'(MAX_ITEMS);
  localparam logic [3:0] LAST_C = 4'(MAX_ITEMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_FLUSH} state_t;

  state_t      r_state;
  logic [29:0] r_buf;
  logic [3:0]  r_count;
  logic        r_out_valid;
  logic [35:0] r_out_data;
  logic        r_flush_done;
  logic        r_trc_d;

  logic        w_slot_free;
  logic        w_item_ready;
  logic        w_accept;
  logic        w_trc_fall;
  logic [29:0] w_ins;
  logic [29:0] w_buf_new;
  logic [3:0]  w_cnt_new;

  // A word slot is usable if empty or being drained on this very edge.
  assign w_slot_free  = !r_out_valid || bus.out_ready;
  assign w_item_ready = (r_state == S_PACK) && ((r_count < LAST_C) || w_slot_free);
  assign w_accept     = bus.item_valid && w_item_ready;
  assign w_trc_fall   = r_trc_d && !trc_on;
  assign w_ins        = {28'd0, bus.item_data} << {r_count, 1'b0};
  assign w_buf_new    = r_buf | w_ins;
  assign w_cnt_new    = r_count + 4'd1;

  assign bus.item_ready = w_item_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign flush_done     = r_flush_done;
  assign dct_buffer     = r_buf;
  assign dct_count      = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_flush_done <= 1'b0;
      r_trc_d      <= 1'b0;
    end else begin
      r_trc_d      <= trc_on;
      r_flush_done <= 1'b0;
      // Drain first; a load below on the same edge overrides it with no bubble.
      if (r_out_valid && bus.out_ready)
        r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_req)
            r_flush_done <= 1'b1;
          if (trc_on)
            r_state <= S_PACK;
        end
        S_PACK: begin
          if (w_accept) begin
            if (w_cnt_new == MAX_C) begin
              r_out_data  <= {2'b00, MAX_C, w_buf_new};
              r_out_valid <= 1'b1;
              r_buf       <= '0;
              r_count     <= '0;
            end else begin
              r_buf   <= w_buf_new;
              r_count <= w_cnt_new;
            end
          end
          if (flush_req || w_trc_fall)
            r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if ((r_count != 4'd0) && w_slot_free) begin
            r_out_data  <= {2'b00, r_count, r_buf};
            r_out_valid <= 1'b1;
            r_buf       <= '0;
            r_count     <= '0;
          end else if ((r_count == 4'd0) && !r_out_valid) begin
            r_flush_done <= 1'b1;
            r_state      <= trc_on ? S_PACK : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef OCI_DTRACE_DROP_CNT_EN
  logic [15:0] r_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_drop <= '0;
    else if ((r_state != S_IDLE) && bus.item_valid && !w_item_ready && (r_drop != 16'hFFFF))
      r_drop <= r_drop + 16'd1;
  end

  assign drop_cnt = r_drop;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_oci_dtrace_packer.sv
// Directed self-checking bench for cpu_oci_dtrace_packer (MAX_ITEMS = 15).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_cpu_oci_dtrace_packer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        flush_req;
  logic        flush_done;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_drop;

  cpu_oci_dtrace_packer_if bus ();

  cpu_oci_dtrace_packer #(.MAX_ITEMS(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .bus        (bus.slave),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; trc_on = 1'b0; flush_req = 1'b0;
    bus.item_valid = 1'b0; bus.item_data = 2'b00; bus.out_ready = 1'b0;
    #1;
    chk("rst_item_ready", 64'(bus.item_ready), 64'd0);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_out_data",   64'(bus.out_data),   64'd0);
    chk("rst_count",      64'(dct_count),      64'd0);
    chk("rst_buffer",     64'(dct_buffer),     64'd0);
    chk("rst_flush_done", 64'(flush_done),     64'd0);
    chk("rst_drop",       64'(drop_cnt),       64'd0);
    tick(); tick();
    reset_n = 1'b1;

    // Fill: 15 x 2'b01 makes one full word
    trc_on = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("pack_item_ready", 64'(bus.item_ready), 64'd1);
    bus.item_valid = 1'b1; bus.item_data = 2'b01;
    for (int i = 0; i < 14; i++) tick();
    chk("fill_count14",  64'(dct_count),  64'd14);
    chk("fill_buf14",    64'(dct_buffer), 64'h0555_5555);
    chk("fill_no_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.item_valid = 1'b0;
    chk("fill_valid",    64'(bus.out_valid), 64'd1);
    chk("fill_data",     64'(bus.out_data), 64'({2'b00, 4'hF, 30'h1555_5555}));
    chk("fill_count0",   64'(dct_count),  64'd0);
    chk("fill_buf0",     64'(dct_buffer), 64'd0);
    tick();
    chk("fill_drained",  64'(bus.out_valid), 64'd0);

    // Partial flush of 11,10,01 with delayed drain
    bus.out_ready = 1'b0;
    bus.item_valid = 1'b1;
    bus.item_data = 2'b11; tick();
    bus.item_data = 2'b10; tick();
    bus.item_data = 2'b01; tick();
    bus.item_valid = 1'b0;
    chk("part_count", 64'(dct_count),  64'd3);
    chk("part_buf",   64'(dct_buffer), 64'h1B);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("flush_item_ready", 64'(bus.item_ready), 64'd0);
    tick();
    chk("part_valid", 64'(bus.out_valid), 64'd1);
    chk("part_data",  64'(bus.out_data), 64'({2'b00, 4'h3, 30'h0000_001B}));
    chk("part_count0", 64'(dct_count), 64'd0);
    tick();
    chk("part_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("part_hold_data",  64'(bus.out_data), 64'({2'b00, 4'h3, 30'h0000_001B}));
    chk("part_no_done",    64'(flush_done), 64'd0);
    bus.out_ready = 1'b1; tick();
    chk("part_drain",      64'(bus.out_valid), 64'd0);
    chk("part_done_early", 64'(flush_done), 64'd0);
    tick();
    chk("part_done", 64'(flush_done), 64'd1);
    tick();
    chk("part_done_pulse", 64'(flush_done), 64'd0);
    chk("part_back_pack",  64'(bus.item_ready), 64'd1);

    // Backpressure: held word plus 14 packed items stalls the 15th
    bus.out_ready = 1'b0;
    bus.item_valid = 1'b1; bus.item_data = 2'b10;
    for (int i = 0; i < 15; i++) tick();
    chk("bp_word_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 14; i++) tick();
    chk("bp_count14",    64'(dct_count), 64'd14);
    chk("bp_item_ready", 64'(bus.item_ready), 64'd0);
    tick();
    chk("bp_count_hold", 64'(dct_count), 64'd14);
    chk("bp_data_hold",  64'(bus.out_data), 64'({2'b00, 4'hF, 30'h2AAA_AAAA}));
    bus.item_data = 2'b11; bus.out_ready = 1'b1; #1;
    chk("bp_ready_on_drain", 64'(bus.item_ready), 64'd1);
    tick();
    bus.item_valid = 1'b0;
    chk("bp_new_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_new_data",  64'(bus.out_data), 64'({2'b00, 4'hF, 30'h3AAA_AAAA}));
    chk("bp_count0",    64'(dct_count), 64'd0);
    tick();
    chk("bp_drained",   64'(bus.out_valid), 64'd0);

    // trc_on falling with 5 items packed
    bus.item_valid = 1'b1; bus.item_data = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    bus.item_valid = 1'b0;
    chk("fall_count5", 64'(dct_count), 64'd5);
    trc_on = 1'b0; tick();
    tick();
    chk("fall_valid", 64'(bus.out_valid), 64'd1);
    chk("fall_data",  64'(bus.out_data), 64'({2'b00, 4'h5, 30'h0000_0155}));
    tick();
    chk("fall_drained", 64'(bus.out_valid), 64'd0);
    tick();
    chk("fall_done",       64'(flush_done), 64'd1);
    chk("fall_item_ready", 64'(bus.item_ready), 64'd0);
    tick();
    chk("fall_done_pulse", 64'(flush_done), 64'd0);
    chk("fall_idle",       64'(bus.item_ready), 64'd0);

    // flush_req in IDLE pulses flush_done and emits nothing
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("idle_flush_done",  64'(flush_done), 64'd1);
    chk("idle_flush_nowrd", 64'(bus.out_valid), 64'd0);
    tick();
    chk("idle_flush_pulse", 64'(flush_done), 64'd0);

    // Reset mid-word
    trc_on = 1'b1; tick();
    bus.item_valid = 1'b1; bus.item_data = 2'b11;
    for (int i = 0; i < 7; i++) tick();
    bus.item_valid = 1'b0;
    chk("mid_count7", 64'(dct_count), 64'd7);
    reset_n = 1'b0; #1;
    chk("mid_rst_count",  64'(dct_count),  64'd0);
    chk("mid_rst_buf",    64'(dct_buffer), 64'd0);
    chk("mid_rst_ready",  64'(bus.item_ready), 64'd0);
    chk("mid_rst_valid",  64'(bus.out_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_restart_done0", 64'(flush_done), 64'd0);
    chk("mid_restart_count", 64'(dct_count), 64'd0);
    tick();
    chk("mid_restart_done1", 64'(flush_done), 64'd0);
    chk("mid_restart_ready", 64'(bus.item_ready), 64'd1);

    // Stall with held word and 14 items, then 20 more item_valid cycles
    bus.out_ready = 1'b0;
    bus.item_valid = 1'b1; bus.item_data = 2'b01;
    for (int i = 0; i < 29; i++) tick();
    chk("drop_pre_count", 64'(dct_count), 64'd14);
    chk("drop_pre_cnt",   64'(drop_cnt), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    bus.item_valid = 1'b0;
`ifdef OCI_DTRACE_DROP_CNT_EN
    exp_drop = 16'd20;
`else
    exp_drop = 16'd0;
`endif
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("drop_count_hold", 64'(dct_count), 64'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
